// File: rtl/cnt_int_unit_pkg.sv
// rtl/cnt_int_unit_pkg.sv - shared constants for the counter-interrupt responder
package cnt_int_unit_pkg;

  localparam int CNT_W_DEFAULT = 32;

  localparam logic TMR0 = 1'b0;
  localparam logic TMR1 = 1'b1;

  localparam logic CMD_LOAD    = 1'b0;
  localparam logic CMD_DISABLE = 1'b1;

endpackage

// File: rtl/cnt_int_timer.sv
// rtl/cnt_int_timer.sv - one periodic down-counter with a sticky pending flag
module cnt_int_timer
  import cnt_int_unit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic             disable_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             clr_pending_i,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             en_q, en_d;
  logic             pend_q, pend_d;

  // A command on the same edge overrides a terminal count; a terminal count
  // overrides the issue-side clear so a fresh event is never dropped.
  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    en_d     = en_q;
    pend_d   = pend_q;
    if (load_i && (period_i != '0)) begin
      period_d = period_i;
      count_d  = period_i;
      en_d     = 1'b1;
      pend_d   = 1'b0;
    end else if (load_i || disable_i) begin
      en_d   = 1'b0;
      pend_d = 1'b0;
    end else begin
      if (clr_pending_i) pend_d = 1'b0;
      if (en_q && tick_i) begin
        if (count_q == ONE) begin
          count_d = period_q;
          pend_d  = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/cnt_int_unit.sv
// rtl/cnt_int_unit.sv - counter-interrupt responder: two timers, issue and rti handshake (option CNT_INT_PRESCALE_EN)
module cnt_int_unit
  import cnt_int_unit_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int PRESCALE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_intE,
  input  logic             cnt_int_selE,
  input  logic             cnt_int_disableE,
  input  logic [CNT_W-1:0] cnt_periodE,
  input  logic             stallE,
  input  logic             stallD,
  input  logic             rti,
  output logic             int_en1,
  output logic             int_src,
  output logic             in_service,
  output logic [1:0]       pending
);

  if (PRESCALE < 1) begin : g_prescale_chk
    $error("PRESCALE must be at least 1");
  end

  logic tick;

`ifdef CNT_INT_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  // Free-running: commands never realign the tick phase.
  always_comb begin
    ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  assign tick = (ps_q == PS_LAST);
`else
  assign tick = 1'b1;
`endif

  logic       cmd_acc;
  logic [1:0] load, dis, clr;
  logic       issue, src_sel;
  logic       int_en1_q, int_en1_d;
  logic       int_src_q, int_src_d;
  logic       in_service_q, in_service_d;

  assign cmd_acc = cnt_intE & ~stallE;

  always_comb begin
    load[0] = cmd_acc & (cnt_int_selE == TMR0) & (cnt_int_disableE == CMD_LOAD);
    load[1] = cmd_acc & (cnt_int_selE == TMR1) & (cnt_int_disableE == CMD_LOAD);
    dis[0]  = cmd_acc & (cnt_int_selE == TMR0) & (cnt_int_disableE == CMD_DISABLE);
    dis[1]  = cmd_acc & (cnt_int_selE == TMR1) & (cnt_int_disableE == CMD_DISABLE);
  end

  // int_en1_q in the issue term keeps requests at least one cycle apart.
  assign issue   = (|pending) & ~in_service_q & ~int_en1_q & ~stallD;
  assign src_sel = pending[0] ? TMR0 : TMR1;
  assign clr[0]  = issue & (src_sel == TMR0);
  assign clr[1]  = issue & (src_sel == TMR1);

  always_comb begin
    int_en1_d    = issue;
    int_src_d    = issue ? src_sel : int_src_q;
    in_service_d = in_service_q;
    if (issue)                             in_service_d = 1'b1;
    else if (rti && !stallD && in_service_q) in_service_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_en1_q    <= 1'b0;
      int_src_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      int_en1_q    <= int_en1_d;
      int_src_q    <= int_src_d;
      in_service_q <= in_service_d;
    end
  end

  for (genvar t = 0; t < 2; t++) begin : g_tmr
    cnt_int_timer #(.CNT_W(CNT_W)) u_tmr (
      .clk_i         (clk),
      .rst_ni        (reset),
      .tick_i        (tick),
      .load_i        (load[t]),
      .disable_i     (dis[t]),
      .period_i      (cnt_periodE),
      .clr_pending_i (clr[t]),
      .pending_o     (pending[t])
    );
  end

  assign int_en1    = int_en1_q;
  assign int_src    = int_src_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_cnt_int_unit.sv
// tb/tb_cnt_int_unit.sv - randomized and directed bench for cnt_int_unit against a behavioural model
module tb_cnt_int_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cnt_intE = 1'b0;
  logic        cnt_int_selE = 1'b0;
  logic        cnt_int_disableE = 1'b0;
  logic [31:0] cnt_periodE = '0;
  logic        stallE = 1'b0;
  logic        stallD = 1'b0;
  logic        rti = 1'b0;
  logic        int_en1, int_src, in_service;
  logic [1:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  cnt_int_unit dut (
    .clk              (clk),
    .reset            (reset),
    .cnt_intE         (cnt_intE),
    .cnt_int_selE     (cnt_int_selE),
    .cnt_int_disableE (cnt_int_disableE),
    .cnt_periodE      (cnt_periodE),
    .stallE           (stallE),
    .stallD           (stallD),
    .rti              (rti),
    .int_en1          (int_en1),
    .int_src          (int_src),
    .in_service       (in_service),
    .pending          (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timers modelled by load edge and period: a timer fires on every edge that
  // lies a positive multiple of its period after the load edge.
  bit       m_en [2];
  int       m_ld [2];
  int       m_per[2];
  bit [1:0] m_pend;
  bit       m_ien, m_src, m_svc;
  int       edge_n;
  bit       m_issue, m_srcsel, m_fire, m_cmd;
  bit [1:0] m_np;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < 2; t++) begin
        m_en[t] = 1'b0; m_ld[t] = 0; m_per[t] = 0;
      end
      m_pend = '0; m_ien = 1'b0; m_src = 1'b0; m_svc = 1'b0;
    end else begin
      edge_n++;
      m_issue  = (m_pend != 2'b00) && !m_svc && !m_ien && !stallD;
      m_srcsel = m_pend[0] ? 1'b0 : 1'b1;
      m_np     = m_pend;
      for (int t = 0; t < 2; t++) begin
        m_fire = m_en[t] && (((edge_n - m_ld[t]) % m_per[t]) == 0);
        m_cmd  = cnt_intE && !stallE && (int'(cnt_int_selE) == t);
        if (m_cmd) begin
          if (!cnt_int_disableE && cnt_periodE != 0) begin
            m_per[t] = int'(cnt_periodE); m_ld[t] = edge_n; m_en[t] = 1'b1;
          end else begin
            m_en[t] = 1'b0;
          end
          m_np[t] = 1'b0;
        end else if (m_fire) begin
          m_np[t] = 1'b1;
        end else if (m_issue && (int'(m_srcsel) == t)) begin
          m_np[t] = 1'b0;
        end
      end
      m_pend = m_np;
      m_ien  = m_issue;
      if (m_issue) m_src = m_srcsel;
      if (m_issue)              m_svc = 1'b1;
      else if (rti && !stallD)  m_svc = 1'b0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      chk("model.int_en1",    int_en1,    m_ien);
      chk("model.int_src",    int_src,    m_src);
      chk("model.in_service", in_service, m_svc);
      chk("model.pending",    pending,    m_pend);
    end
  end

  task automatic nxt(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic cmd(input bit sel, input bit dis, input int p);
    cnt_intE = 1'b1; cnt_int_selE = sel; cnt_int_disableE = dis; cnt_periodE = p;
    @(negedge clk);
    cnt_intE = 1'b0;
  endtask

  task automatic quiesce();
    stallD = 1'b1;
    cmd(1'b0, 1'b1, 0);
    cmd(1'b1, 1'b1, 0);
    stallD = 1'b0;
    rti = 1'b1;
    nxt(2);
    rti = 1'b0;
  endtask

  initial begin
    nxt(2);
    chk("reset.int_en1", int_en1, 0);
    chk("reset.int_src", int_src, 0);
    chk("reset.in_service", in_service, 0);
    chk("reset.pending", pending, 0);
    reset = 1'b1;
    chk_on = 1'b1;
    nxt(1);

    cmd(1'b0, 1'b0, 5);
    nxt(5);
    chk("t1.pend_at5", pending, 2'b01);
    chk("t1.no_req_at5", int_en1, 0);
    nxt(1);
    chk("t1.req_at6", int_en1, 1);
    chk("t1.src_at6", int_src, 0);
    chk("t1.svc_at6", in_service, 1);
    chk("t1.pend_at6", pending, 2'b00);
    nxt(1);
    chk("t1.pulse_end", int_en1, 0);
    nxt(3);
    chk("t1.pend_at10", pending, 2'b01);
    chk("t1.held_at10", int_en1, 0);
    nxt(1);
    rti = 1'b1; nxt(1); rti = 1'b0;
    chk("t1.svc_clr_at12", in_service, 0);
    chk("t1.gap_at12", int_en1, 0);
    nxt(1);
    chk("t1.req_at13", int_en1, 1);
    rti = 1'b1; nxt(1); rti = 1'b0;
    cmd(1'b0, 1'b1, 0);
    chk("t1.dis_on_tc", pending, 2'b00);

    cmd(1'b0, 1'b0, 4);
    cmd(1'b1, 1'b0, 4);
    nxt(4);
    chk("t2.req0", int_en1, 1);
    chk("t2.src0", int_src, 0);
    chk("t2.pend1", pending, 2'b10);
    rti = 1'b1; nxt(1); rti = 1'b0;
    chk("t2.svc_clr", in_service, 0);
    nxt(1);
    chk("t2.req1", int_en1, 1);
    chk("t2.src1", int_src, 1);
    quiesce();

    cmd(1'b1, 1'b0, 3);
    nxt(2);
    cmd(1'b1, 1'b1, 0);
    chk("t3.dis_on_tc", pending, 2'b00);
    nxt(5);
    chk("t3.never", pending, 2'b00);
    chk("t3.idle", in_service, 0);

    stallD = 1'b1;
    cmd(1'b0, 1'b0, 3);
    nxt(3);
    chk("t4.pend", pending, 2'b01);
    chk("t4.stalled", int_en1, 0);
    nxt(2);
    chk("t4.stalled2", int_en1, 0);
    stallD = 1'b0;
    nxt(1);
    chk("t4.release", int_en1, 1);
    quiesce();

    stallE = 1'b1;
    cnt_intE = 1'b1; cnt_int_selE = 1'b1; cnt_int_disableE = 1'b0; cnt_periodE = 2;
    nxt(3);
    chk("t5.held_cmd", pending, 2'b00);
    stallE = 1'b0;
    nxt(1);
    cnt_intE = 1'b0;
    nxt(2);
    chk("t5.applied", pending, 2'b10);
    quiesce();

    cmd(1'b0, 1'b0, 0);
    nxt(10);
    chk("t6.zero_period", pending, 2'b00);

    cmd(1'b0, 1'b0, 3);
    nxt(2);
    reset = 1'b0;
    #1;
    chk("t7.rst_pend", pending, 0);
    chk("t7.rst_svc", in_service, 0);
    chk("t7.rst_req", int_en1, 0);
    nxt(1);
    reset = 1'b1;
    nxt(10);
    chk("t7.after_rst", pending, 2'b00);

    for (int i = 0; i < 4000; i++) begin
      cnt_intE         = ($urandom_range(0, 7) == 0);
      cnt_int_selE     = $urandom_range(0, 1);
      cnt_int_disableE = ($urandom_range(0, 3) == 0);
      cnt_periodE      = $urandom_range(0, 6);
      stallE           = ($urandom_range(0, 3) == 0);
      stallD           = ($urandom_range(0, 3) == 0);
      rti              = ($urandom_range(0, 2) == 0);
      reset            = ($urandom_range(0, 399) != 0);
      nxt(1);
    end
    reset = 1'b1;
    cnt_intE = 1'b0; stallE = 1'b0; stallD = 1'b0; rti = 1'b0;
    nxt(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
